// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide unit.
// The EX stage drives the master side; the unit implements the slave side.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OperandA, OperandB,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB,
        output Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 iterative datapath: WIDTH shift-add steps for multiplies, WIDTH
// restoring steps for divides, then one FIX cycle that applies signs and
// writes HI/LO. Busy is the EX-stage stall request while an op runs.
// Optional feature: define HILO_MADD_EN to enable MADD/MSUB accumulation;
// without it, ops 110/111 complete immediately as no-ops.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    hilo_muldiv_unit_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DZ,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    // Multiply: {partial product, remaining multiplier}; divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude or divisor magnitude.
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    // neg_lo: negate product / quotient; neg_hi: negate remainder.
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_signed;

    // Operand magnitudes for the signed ops; unsigned ops pass operands through.
    always_comb begin
        op_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV) ||
                    (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
        abs_a = (op_signed && bus.OperandA[WIDTH-1]) ? -bus.OperandA : bus.OperandA;
        abs_b = (op_signed && bus.OperandB[WIDTH-1]) ? -bus.OperandB : bus.OperandB;
    end

    // One radix-2 step of each datapath, plus the signed 2*WIDTH product.
    always_comb begin
        // Shift-add: add multiplicand to the upper half when the multiplier LSB is set,
        // then shift the whole accumulator right, keeping the carry.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
        // Restoring divide: shift next dividend bit into the remainder, trial-subtract,
        // keep the difference only if it did not go negative.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_diff[WIDTH]) begin
            div_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        prod_signed = neg_lo_q ? -acc_q : acc_q;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
`ifdef HILO_MADD_EN
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
`else
                        OP_MULT, OP_MULTU: begin
`endif
                            state_d  = S_MUL;
                            acc_d    = {{WIDTH{1'b0}}, abs_b};
                            opb_d    = abs_a;
                            cnt_d    = '0;
                            op_d     = bus.Op;
                            neg_lo_d = op_signed &&
                                       (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
                            neg_hi_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.OperandB == '0) begin
                                state_d = S_DZ;
                            end else begin
                                state_d  = S_DIV;
                                acc_d    = {{WIDTH{1'b0}}, abs_a};
                                opb_d    = abs_b;
                                cnt_d    = '0;
                                op_d     = bus.Op;
                                neg_lo_d = op_signed &&
                                           (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
                                neg_hi_d = op_signed && bus.OperandA[WIDTH-1];
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = bus.OperandA;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.OperandA;
                            done_d = 1'b1;
                        end
                        default: begin
                            // Accumulate ops without the accumulate feature: complete at once.
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_DZ: begin
                done_d  = 1'b1;
                dbz_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_FIX: begin
                case (op_q)
                    OP_DIV, OP_DIVU: begin
                        lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end
`ifdef HILO_MADD_EN
                    // HI/LO are sampled here, so the accumulate sees the value at completion.
                    OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_signed;
                    OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_signed;
`endif
                    default: {hi_d, lo_d} = prod_signed;
                endcase
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset discards any op in flight and clears HI/LO.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit (WIDTH=32). Expected HI/LO come from
// a plain-arithmetic model using 64-bit signed/unsigned multiply, divide and modulo.
// Honours HILO_MADD_EN the same way as the design.
`define CHK(tag, what, obs, exp) \
    begin \
        n_cmp++; \
        assert ((obs) === (exp)) else begin \
            n_bad++; \
            $error("FAIL %s/%s: observed=%0h expected=%0h", tag, what, (obs), (exp)); \
        end \
    end

module tb_hilo_muldiv_unit;
    localparam int WIDTH = 32;

    logic        Clk = 1'b0;
    logic        Reset;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Issue one op, follow it to completion and check against the model.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] e_hi, e_lo;
        logic        e_dz;
        int          lat, n;
        longint      sp, sq, sr;
        logic [63:0] acc;
        logic        busy_bad, hold_bad;

        e_hi = m_hi;
        e_lo = m_lo;
        e_dz = 1'b0;
        lat  = WIDTH + 1;
        sp   = longint'($signed(a)) * longint'($signed(b));
        case (op)
            3'd0: {e_hi, e_lo} = sp;
            3'd1: {e_hi, e_lo} = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) begin
                    e_dz = 1'b1;
                    lat  = 1;
                end else begin
                    sq   = longint'($signed(a)) / longint'($signed(b));
                    sr   = longint'($signed(a)) % longint'($signed(b));
                    e_lo = 32'(sq);
                    e_hi = 32'(sr);
                end
            end
            3'd3: begin
                if (b == 0) begin
                    e_dz = 1'b1;
                    lat  = 1;
                end else begin
                    e_lo = a / b;
                    e_hi = a % b;
                end
            end
            3'd4: begin e_hi = a; lat = 0; end
            3'd5: begin e_lo = a; lat = 0; end
            default: begin
`ifdef HILO_MADD_EN
                acc = {m_hi, m_lo};
                acc = (op == 3'd6) ? acc + 64'(sp) : acc - 64'(sp);
                {e_hi, e_lo} = acc;
`else
                lat = 0;
`endif
            end
        endcase

        @(negedge Clk);
        bus.Start    = 1'b1;
        bus.Op       = op;
        bus.OperandA = a;
        bus.OperandB = b;
        @(posedge Clk);
        #1;
        bus.Start    = 1'b0;
        bus.Op       = 3'($urandom);
        bus.OperandA = $urandom;
        bus.OperandB = $urandom;

        if (lat == 0) begin
            `CHK(tag, "done_e0", bus.Done, 1'b1)
            `CHK(tag, "busy_e0", bus.Busy, 1'b0)
            `CHK(tag, "hi", bus.Hi, e_hi)
            `CHK(tag, "lo", bus.Lo, e_lo)
        end else begin
            `CHK(tag, "busy_e0", bus.Busy, 1'b1)
            `CHK(tag, "done_e0", bus.Done, 1'b0)
            busy_bad = 1'b0;
            hold_bad = 1'b0;
            n = 0;
            do begin
                if (bus.Busy !== 1'b1) busy_bad = 1'b1;
                if (bus.Hi !== m_hi || bus.Lo !== m_lo) hold_bad = 1'b1;
                @(posedge Clk);
                #1;
                n++;
            end while (bus.Done !== 1'b1 && n < 40);
            n_cmp++;
            if (bus.Done !== 1'b1) begin
                n_bad++;
                $error("FAIL %s/timeout: Done not seen within %0d cycles", tag, n);
            end
            `CHK(tag, "latency", n, lat)
            `CHK(tag, "busy_during", busy_bad, 1'b0)
            `CHK(tag, "hilo_hold", hold_bad, 1'b0)
            `CHK(tag, "busy_end", bus.Busy, 1'b0)
            `CHK(tag, "dbz", bus.DivByZero, e_dz)
            `CHK(tag, "hi", bus.Hi, e_hi)
            `CHK(tag, "lo", bus.Lo, e_lo)
        end
        m_hi = e_hi;
        m_lo = e_lo;
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dbz=%0d (%s)",
                 op, a, b, bus.Hi, bus.Lo, bus.DivByZero, tag);
        @(posedge Clk);
        #1;
        `CHK(tag, "done_pulse", bus.Done, 1'b0)
        `CHK(tag, "dbz_pulse", bus.DivByZero, 1'b0)
    endtask

    initial begin
        longint      sp;
        logic        busy_bad;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        Reset        = 1'b1;
        bus.Start    = 1'b0;
        bus.Op       = '0;
        bus.OperandA = '0;
        bus.OperandB = '0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.DivByZero !== 1'b0 ||
            bus.Hi !== 32'h0 || bus.Lo !== 32'h0) begin
            n_bad++;
            $error("FAIL reset/state: busy=%0b done=%0b dbz=%0b hi=%0h lo=%0h",
                   bus.Busy, bus.Done, bus.DivByZero, bus.Hi, bus.Lo);
        end
        `CHK("reset", "busy", bus.Busy, 1'b0)
        `CHK("reset", "done", bus.Done, 1'b0)
        `CHK("reset", "dbz", bus.DivByZero, 1'b0)
        `CHK("reset", "hi", bus.Hi, 32'h0)
        `CHK("reset", "lo", bus.Lo, 32'h0)

        // Reset in the middle of a multiply clears HI/LO and discards the op.
        run_op(3'd4, 32'hDEAD_BEEF, 32'h0, "mthi_pre");
        run_op(3'd5, 32'hCAFE_F00D, 32'h0, "mtlo_pre");
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 3'd0; bus.OperandA = $urandom; bus.OperandB = $urandom;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        `CHK("rst_mid", "busy", bus.Busy, 1'b0)
        `CHK("rst_mid", "hi", bus.Hi, 32'h0)
        `CHK("rst_mid", "lo", bus.Lo, 32'h0)
        m_hi = '0;
        m_lo = '0;
        repeat (3) @(posedge Clk);
        #1;
        `CHK("rst_mid", "no_done", bus.Done, 1'b0)
        run_op(3'd1, 32'd3, 32'd5, "multu_3x5");
        `CHK("multu_3x5", "lo_lit", bus.Lo, 32'd15)

        // Directed multiply/divide corner cases.
        run_op(3'd0, 32'hFFFF_FFFE, 32'd7, "mult_m2x7");
        `CHK("mult_m2x7", "hi_lit", bus.Hi, 32'hFFFF_FFFF)
        `CHK("mult_m2x7", "lo_lit", bus.Lo, 32'hFFFF_FFF2)
        run_op(3'd1, 32'hFFFF_FFFE, 32'd7, "multu_m2x7");
        `CHK("multu_m2x7", "hi_lit", bus.Hi, 32'd6)
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
        `CHK("div_m7d2", "lo_lit", bus.Lo, 32'hFFFF_FFFD)
        `CHK("div_m7d2", "hi_lit", bus.Hi, 32'hFFFF_FFFF)
        run_op(3'd3, 32'd100, 32'd7, "divu_100d7");
        `CHK("divu_100d7", "lo_lit", bus.Lo, 32'd14)
        `CHK("divu_100d7", "hi_lit", bus.Hi, 32'd2)
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_minint");
        `CHK("div_minint", "lo_lit", bus.Lo, 32'h8000_0000)
        `CHK("div_minint", "hi_lit", bus.Hi, 32'h0)

        // Divide by zero leaves HI/LO untouched.
        run_op(3'd4, 32'hAA, 32'h0, "mthi_aa");
        run_op(3'd5, 32'hBB, 32'h0, "mtlo_bb");
        run_op(3'd2, 32'd5, 32'd0, "div_5d0");
        `CHK("div_5d0", "hi_lit", bus.Hi, 32'hAA)
        `CHK("div_5d0", "lo_lit", bus.Lo, 32'hBB)
        run_op(3'd3, 32'd9, 32'd0, "divu_9d0");

        // Start while busy (MTHI at edge 5) must be ignored.
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 3'd0; bus.OperandA = 32'hFFFF_FFFD; bus.OperandB = 32'h1000;
        sp = longint'($signed(32'hFFFF_FFFD)) * longint'(32'h1000);
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        busy_bad  = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) busy_bad = 1'b1;
            if (k == 5) begin
                bus.Start = 1'b1; bus.Op = 3'd4; bus.OperandA = 32'h1234;
            end
            @(posedge Clk);
            #1;
            if (k == 5) bus.Start = 1'b0;
        end
        if (bus.Busy !== 1'b1 || bus.Hi === 32'h1234) busy_bad = 1'b1;
        @(posedge Clk);
        #1;
        {m_hi, m_lo} = sp;
        `CHK("busy_ign", "busy_0_32", busy_bad, 1'b0)
        `CHK("busy_ign", "done", bus.Done, 1'b1)
        `CHK("busy_ign", "busy_end", bus.Busy, 1'b0)
        `CHK("busy_ign", "hi", bus.Hi, m_hi)
        `CHK("busy_ign", "lo", bus.Lo, m_lo)
        @(posedge Clk);
        #1;

        // Accumulate sequence (no-op without HILO_MADD_EN).
        run_op(3'd4, 32'h0, 32'h0, "mthi_0");
        run_op(3'd5, 32'hFFFF_FFFF, 32'h0, "mtlo_ff");
        run_op(3'd6, 32'd1, 32'd1, "madd_1x1");
`ifdef HILO_MADD_EN
        `CHK("madd_1x1", "hi_lit", bus.Hi, 32'd1)
        `CHK("madd_1x1", "lo_lit", bus.Lo, 32'd0)
`else
        `CHK("madd_1x1", "hi_lit", bus.Hi, 32'd0)
        `CHK("madd_1x1", "lo_lit", bus.Lo, 32'hFFFF_FFFF)
`endif
        run_op(3'd7, 32'd1, 32'd1, "msub_1x1");
        `CHK("msub_1x1", "hi_lit", bus.Hi, 32'd0)
        `CHK("msub_1x1", "lo_lit", bus.Lo, 32'hFFFF_FFFF)

        // Randomized ops against the model.
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($signed(4'($urandom)));
            if ($urandom_range(0, 7) == 0) rb = '0;
            run_op(rop, ra, rb, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
